spkr_dac_spi_tx: RTL and testbench

- Sink side of the speaker signal path: takes the four 12-bit speaker drive words and writes them serially to a quad 12-bit SPI DAC.
- On each sample strobe it snapshots all four channels and sends four 16-bit frames (one per channel) in SPI mode 0.
- It then pulses the DAC's LDAC line so all four outputs update simultaneously.
- Sits between the speaker inverter stage and the board DAC pins.

---
 rtl/spkr_dac_spi_tx.sv | 162 ++++++++++++++++
 tb/tb_spkr_dac_spi_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spkr_dac_spi_tx.sv
// spkr_dac_spi_tx: snapshots four 12-bit speaker words and writes them as
// 16-bit SPI mode-0 frames to a quad DAC, then pulses LDAC to update all outputs together.
module spkr_dac_spi_tx #(
    parameter int         CLK_DIV = 2,
    parameter int         CS_GAP  = 2,
    parameter int         LDAC_W  = 2,
    parameter logic [1:0] CTRL    = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] ch1,
    input  logic [11:0] ch2,
    input  logic [11:0] ch3,
    input  logic [11:0] ch4,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        ldac_n,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    typedef enum logic [2:0] {IDLE, SHIFT, GAP, LDAC, DONE} state_t;

    localparam logic [15:0] DIV_M  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_M  = 16'(CS_GAP - 1);
    localparam logic [15:0] LDAC_M = 16'(LDAC_W - 1);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  ch_q, ch_d;
    logic [11:0] snap_q [4];
    logic [11:0] snap_d [4];
    logic        sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, ldac_n_q, ldac_n_d;
    logic        busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
    logic [1:0]  ch_nx;
    logic [3:0]  nb;
    logic [15:0] frame_cur, frame_nxt, frame_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            ch_q      <= '0;
            snap_q    <= '{default: '0};
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            ldac_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            ch_q      <= ch_d;
            snap_q    <= snap_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            ldac_n_q  <= ldac_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // bit_q counts up from 0; the next bit to present is frame[14-bit_q] = frame[~(bit_q+1)]
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        ch_d        = ch_q;
        snap_d      = snap_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        ldac_n_d    = ldac_n_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overrun_d   = start && busy_q;
        ch_nx       = ch_q + 2'd1;
        nb          = bit_q + 4'd1;
        frame_cur   = {ch_q, CTRL, snap_q[ch_q]};
        frame_nxt   = {ch_nx, CTRL, snap_q[ch_nx]};
        frame_first = {2'b00, CTRL, ch1};
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    snap_d  = '{ch1, ch2, ch3, ch4};
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    mosi_d  = frame_first[15];
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    ch_d    = '0;
                end
            end
            SHIFT: begin
                div_d = div_q + 16'd1;
                if (div_q == DIV_M) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == 4'd15) begin
                        sclk_d  = 1'b0;
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = GAP;
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = nb;
                        mosi_d = frame_cur[~nb];
                    end
                end
            end
            GAP: begin
                mosi_d = 1'b0;
                div_d  = div_q + 16'd1;
                if (div_q == GAP_M) begin
                    div_d = '0;
                    if (ch_q == 2'd3) begin
                        ldac_n_d = 1'b0;
                        state_d  = LDAC;
                    end else begin
                        ch_d    = ch_nx;
                        bit_d   = '0;
                        cs_n_d  = 1'b0;
                        mosi_d  = frame_nxt[15];
                        state_d = SHIFT;
                    end
                end
            end
            LDAC: begin
                div_d = div_q + 16'd1;
                if (div_q == LDAC_M) begin
                    div_d    = '0;
                    ldac_n_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign ldac_n  = ldac_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_spkr_dac_spi_tx.sv
// tb_spkr_dac_spi_tx: directed bench for the quad DAC SPI writer (default and fastest timing).
module tb_spkr_dac_spi_tx;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [11:0] ch1 = '0, ch2 = '0, ch3 = '0, ch4 = '0;
    logic sclk, mosi, cs_n, ldac_n, busy, done, overrun;
    logic sclk1, mosi1, cs_n1, ldac_n1, busy1, done1, overrun1;
    int cyc = 0, t0 = 0, npass = 0, nchk = 0, nfail = 0;

    spkr_dac_spi_tx dut (
        .clk(clk), .rst(rst), .start(start), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .ldac_n(ldac_n), .busy(busy), .done(done),
        .overrun(overrun)
    );

    spkr_dac_spi_tx #(.CLK_DIV(1), .CS_GAP(1), .LDAC_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
        .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .ldac_n(ldac_n1), .busy(busy1), .done(done1),
        .overrun(overrun1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI monitors, sampled on the falling clk edge
    logic [15:0] sh = '0, frames [8];
    int lens [8], dcyc [4];
    int nf = 0, cs_len = 0, ldac_len = 0, ndone = 0, nov = 0, viol = 0;
    logic sclk_p = 1'b0, cs_n_p = 1'b1, mosi_p = 1'b0;
    logic [15:0] sh1 = '0, frames1 [8];
    int lens1 [8];
    int nf1 = 0, cs_len1 = 0, nd1 = 0, dcyc1 = 0;
    logic sclk1_p = 1'b0, cs_n1_p = 1'b1;

    always @(negedge clk) begin
        if (!cs_n) cs_len++;
        if (sclk && !sclk_p) sh = {sh[14:0], mosi};
        if (cs_n && !cs_n_p) begin
            if (nf < 8) begin
                frames[nf] = sh;
                lens[nf] = cs_len;
            end
            nf++;
            cs_len = 0;
        end
        if (!cs_n && !cs_n_p && mosi != mosi_p && !(sclk_p && !sclk)) viol++;
        if (!ldac_n) ldac_len++;
        if (done) begin
            if (ndone < 4) dcyc[ndone] = cyc;
            ndone++;
        end
        if (overrun) nov++;
        sclk_p = sclk;
        cs_n_p = cs_n;
        mosi_p = mosi;
        if (!cs_n1) cs_len1++;
        if (sclk1 && !sclk1_p) sh1 = {sh1[14:0], mosi1};
        if (cs_n1 && !cs_n1_p) begin
            if (nf1 < 8) begin
                frames1[nf1] = sh1;
                lens1[nf1] = cs_len1;
            end
            nf1++;
            cs_len1 = 0;
        end
        if (done1) begin
            if (nd1 == 0) dcyc1 = cyc;
            nd1++;
        end
        sclk1_p = sclk1;
        cs_n1_p = cs_n1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        nf = 0; cs_len = 0; ldac_len = 0; ndone = 0; nov = 0; viol = 0; sh = '0;
        nf1 = 0; cs_len1 = 0; nd1 = 0; sh1 = '0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int lim);
        for (int i = 0; i < lim && ndone < n; i++) @(negedge clk);
        chk("done_timeout", 32'(ndone >= n), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        for (int i = 0; i < 2000 && cyc < c; i++) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {sclk, mosi, cs_n, ldac_n, busy, done, overrun}, 7'b0011000);
        rst = 1'b0;
        @(negedge clk);
        clr();

        // basic transaction, both timings
        ch1 = 12'h0F0; ch2 = 12'hA55; ch3 = 12'h000; ch4 = 12'hFFF;
        pulse_start();
        chk("busy_after_latch", {busy, cs_n}, 2'b10);
        wait_done(1, 400);
        chk("nframes", nf, 4);
        chk("frame0", frames[0], 16'h10F0);
        chk("frame1", frames[1], 16'h5A55);
        chk("frame2", frames[2], 16'h9000);
        chk("frame3", frames[3], 16'hDFFF);
        for (int i = 0; i < 4; i++) chk("cs_low_len", lens[i], 64);
        chk("ldac_len", ldac_len, 2);
        chk("done_latency", dcyc[0] - t0, 266);
        chk("ndone", ndone, 1);
        chk("mosi_stable", viol, 0);
        chk("no_overrun", nov, 0);
        chk("idle_after", {busy, cs_n, ldac_n}, 3'b011);
        chk("f1_frame0", frames1[0], 16'h10F0);
        chk("f1_frame3", frames1[3], 16'hDFFF);
        chk("f1_cs_low_len", lens1[0], 32);
        chk("f1_done_latency", dcyc1 - t0, 133);

        // inputs changing every cycle after the latch edge
        clr();
        ch1 = 12'h123; ch2 = 12'h456; ch3 = 12'h789; ch4 = 12'hABC;
        pulse_start();
        for (int i = 0; i < 400 && ndone == 0; i++) begin
            ch1 = 12'($urandom); ch2 = 12'($urandom); ch3 = 12'($urandom); ch4 = 12'($urandom);
            @(negedge clk);
        end
        wait_done(1, 10);
        chk("snap_frame0", frames[0], 16'h1123);
        chk("snap_frame1", frames[1], 16'h5456);
        chk("snap_frame2", frames[2], 16'h9789);
        chk("snap_frame3", frames[3], 16'hDABC);

        // starts during a transaction are dropped with overrun
        ch1 = 12'h000; ch2 = 12'hFFF; ch3 = 12'h800; ch4 = 12'h001;
        repeat (20) @(negedge clk);
        clr();
        pulse_start();
        wait_cyc(t0 + 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(t0 + 100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, 400);
        repeat (20) @(negedge clk);
        chk("overrun_count", nov, 2);
        chk("ovr_ndone", ndone, 1);
        chk("ovr_nframes", nf, 4);
        chk("ovr_latency", dcyc[0] - t0, 266);

        // async reset mid frame 2, during SCLK high
        clr();
        pulse_start();
        wait_cyc(t0 + 68);
        chk("pre_rst_sclk_cs", {sclk, cs_n}, 2'b10);
        chk("pre_rst_nframes", nf, 1);
        rst = 1'b1;
        #1;
        chk("rst_async", {sclk, cs_n, ldac_n, busy}, 4'b0110);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("rst_no_ldac", ldac_len, 0);
        chk("rst_no_done", ndone, 0);
        clr();
        pulse_start();
        wait_done(1, 400);
        chk("post_rst_nframes", nf, 4);
        chk("post_rst_frame0", frames[0], 16'h1000);
        chk("post_rst_frame1", frames[1], 16'h5FFF);
        chk("post_rst_frame2", frames[2], 16'h9800);
        chk("post_rst_frame3", frames[3], 16'hD001);
        chk("post_rst_ldac", ldac_len, 2);

        // start held high: back-to-back transactions
        repeat (20) @(negedge clk);
        clr();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        repeat (599) @(negedge clk);
        start = 1'b0;
        wait_done(3, 400);
        chk("b2b_ndone", ndone, 3);
        chk("b2b_first", dcyc[0] - t0, 266);
        chk("b2b_gap1", dcyc[1] - dcyc[0], 267);
        chk("b2b_gap2", dcyc[2] - dcyc[1], 267);
        chk("b2b_overrun", nov, 597);
        chk("b2b_nframes", nf, 12);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
